// File: rtl/atm_disp_pkg.sv
// Shared definitions for the ATM text display: default character width,
// character codes and the scroller FSM state encoding.
package atm_disp_pkg;

  localparam int CHAR_W_DEF = 5;

  // Character codes: 0 is blank, 1..26 are A..Z.
  localparam logic [4:0] CH_BLANK = 5'd0;
  localparam logic [4:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
  localparam logic [4:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
  localparam logic [4:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
  localparam logic [4:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
  localparam logic [4:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
  localparam logic [4:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
  localparam logic [4:0] CH_Y = 5'd25, CH_Z = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_GAP    = 2'd2
  } scr_state_e;

endpackage

// File: rtl/step_divider.sv
// Scroll step divider: counts 0..STEP_DIV-1 while enabled and raises tick
// on the last count, then wraps. clr forces the count back to 0.
module step_divider #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/inst_scroller.sv
// Message scroller for the ATM display character bus. Loads up to MSG_MAX
// codes, then shifts them one per step into a DISP_CHARS window followed by
// GAP_CHARS blanks, one-shot or looping. Optional macro
// INST_SCROLLER_HOLD_EN adds a hold input that pauses stepping.
module inst_scroller
  import atm_disp_pkg::*;
#(
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int DISP_CHARS = 8,
  parameter int MSG_MAX    = 16,
  parameter int STEP_DIV   = 4,
  parameter int GAP_CHARS  = 8,
  parameter int IDX_W      = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1,
  parameter int LEN_W      = $clog2(MSG_MAX + 1)
) (
  input  logic                         sec_clock,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [IDX_W-1:0]             load_idx,
  input  logic [CHAR_W-1:0]            load_char,
  input  logic [LEN_W-1:0]             msg_len,
  input  logic                         start,
  input  logic                         loop_mode,
  input  logic                         stop,
`ifdef INST_SCROLLER_HOLD_EN
  input  logic                         hold,
`endif
  output logic [DISP_CHARS*CHAR_W-1:0] instruction,
  output logic                         busy,
  output logic                         done
);

  localparam int WIN_W = DISP_CHARS * CHAR_W;
  localparam int GAP_W = $clog2(GAP_CHARS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CHARS - 1);

  scr_state_e        state_q, state_d;
  logic [WIN_W-1:0]  instr_q, instr_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              loop_q, loop_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic [CHAR_W-1:0] msg_q [MSG_MAX];
  logic              hold_act;
  logic              tick;

`ifdef INST_SCROLLER_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  step_divider #(.STEP_DIV(STEP_DIV)) u_div (
    .clk  (sec_clock),
    .rst_n(rst_n),
    .clr  ((state_q == ST_IDLE) || stop),
    .en   ((state_q != ST_IDLE) && !hold_act),
    .tick (tick)
  );

  // Message buffer: host writes accepted only while idle and in range.
  always_ff @(posedge sec_clock or negedge rst_n) begin
    // NOTE: the buffer is reset explicitly because a reset must blank every slot.
    if (!rst_n) begin
      for (int i = 0; i < MSG_MAX; i++) msg_q[i] <= '0;
    end else if (load && (state_q == ST_IDLE) && (int'(load_idx) < MSG_MAX)) begin
      msg_q[load_idx] <= load_char;
    end
  end

  // Next-state and window update: accept, abort, message shift, gap shift.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gap_d   = gap_q;
    loop_d  = loop_q;
    fin_d   = 1'b0;
    done_d  = fin_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (msg_len != '0)) begin
          state_d = ST_SCROLL;
          len_d   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
          loop_d  = loop_mode;
          instr_d = '0;
          idx_d   = '0;
        end
      end
      ST_SCROLL: begin
        if (stop) begin
          state_d = ST_IDLE;
          instr_d = '0;
        end else if (tick) begin
          instr_d = (instr_q << CHAR_W) | WIN_W'(msg_q[idx_q[IDX_W-1:0]]);
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          instr_d = '0;
        end else if (tick) begin
          instr_d = instr_q << CHAR_W;
          if (gap_q == GAP_LAST) begin
            if (loop_q) begin
              state_d = ST_SCROLL;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
              fin_d   = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; done trails the completing edge by one cycle.
  always_ff @(posedge sec_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      loop_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      loop_q  <= loop_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign instruction = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
